// File: rtl/checkout_flagger_seq.sv
// Clocked UPC discount/theft flagger: one item per handshake, saturating counters, latched alarm.
// Optional alarm auto-clear timer is enabled by defining CHECKOUT_ALARM_AUTOCLR_EN.
module checkout_flagger_seq #(
    parameter int                  UPC_W      = 3,
    parameter logic [2**UPC_W-1:0] DISC_MASK  = 'h26,
    parameter logic [2**UPC_W-1:0] EXP_MASK   = 'h89,
    parameter int                  CNT_W      = 8,
    parameter int                  ALARM_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             scan_valid,
    output logic             scan_ready,
    input  logic [UPC_W-1:0] scan_upc,
    input  logic             scan_mark,
    input  logic             alarm_ack,
    output logic             discounted,
    output logic             stolen_alarm,
    output logic [UPC_W-1:0] last_upc,
    output logic             last_valid,
    output logic [CNT_W-1:0] item_count,
    output logic [CNT_W-1:0] stolen_count
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_ALARM} state_t;

    state_t             state_q, state_d;
    logic [UPC_W-1:0]   upc_q, upc_d;
    logic               mark_q, mark_d;
    logic               ready_q, ready_d;
    logic               disc_q, disc_d;
    logic               alarm_q, alarm_d;
    logic [UPC_W-1:0]   last_upc_q, last_upc_d;
    logic               last_valid_q, last_valid_d;
    logic [CNT_W-1:0]   item_cnt_q, item_cnt_d;
    logic [CNT_W-1:0]   stolen_cnt_q, stolen_cnt_d;
    logic               take;
    logic               is_stolen;
    logic               timer_expired;

    assign take      = scan_valid & ready_q;
    assign is_stolen = EXP_MASK[upc_q] & ~mark_q;

`ifdef CHECKOUT_ALARM_AUTOCLR_EN
    localparam int TMR_W = (ALARM_HOLD < 2) ? 1 : $clog2(ALARM_HOLD + 1);
    logic [TMR_W-1:0] timer_q;

    // Loaded while evaluating so it is full on the first ALARM cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else if (state_q == S_EVAL) begin
            timer_q <= TMR_W'(ALARM_HOLD);
        end else if (state_q == S_ALARM && timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
        end
    end

    assign timer_expired = (state_q == S_ALARM) && (timer_q <= TMR_W'(1));
`else
    assign timer_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (take) state_d = S_EVAL;
            S_EVAL:  state_d = is_stolen ? S_ALARM : S_IDLE;
            S_ALARM: if (alarm_ack || timer_expired) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        upc_d        = upc_q;
        mark_d       = mark_q;
        disc_d       = disc_q;
        alarm_d      = alarm_q;
        last_upc_d   = last_upc_q;
        last_valid_d = last_valid_q;
        item_cnt_d   = item_cnt_q;
        stolen_cnt_d = stolen_cnt_q;
        ready_d      = (state_d == S_IDLE);
        if (state_q == S_IDLE && take) begin
            upc_d  = scan_upc;
            mark_d = scan_mark;
        end
        if (state_q == S_EVAL) begin
            disc_d       = DISC_MASK[upc_q];
            last_upc_d   = upc_q;
            last_valid_d = 1'b1;
            if (item_cnt_q != '1) item_cnt_d = item_cnt_q + 1'b1;
            if (is_stolen) begin
                alarm_d = 1'b1;
                if (stolen_cnt_q != '1) stolen_cnt_d = stolen_cnt_q + 1'b1;
            end
        end
        if (state_q == S_ALARM && state_d == S_IDLE) alarm_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            upc_q        <= '0;
            mark_q       <= 1'b0;
            ready_q      <= 1'b1;
            disc_q       <= 1'b0;
            alarm_q      <= 1'b0;
            last_upc_q   <= '0;
            last_valid_q <= 1'b0;
            item_cnt_q   <= '0;
            stolen_cnt_q <= '0;
        end else begin
            upc_q        <= upc_d;
            mark_q       <= mark_d;
            ready_q      <= ready_d;
            disc_q       <= disc_d;
            alarm_q      <= alarm_d;
            last_upc_q   <= last_upc_d;
            last_valid_q <= last_valid_d;
            item_cnt_q   <= item_cnt_d;
            stolen_cnt_q <= stolen_cnt_d;
        end
    end

    assign scan_ready   = ready_q;
    assign discounted   = disc_q;
    assign stolen_alarm = alarm_q;
    assign last_upc     = last_upc_q;
    assign last_valid   = last_valid_q;
    assign item_count   = item_cnt_q;
    assign stolen_count = stolen_cnt_q;

endmodule

// File: tb/tb_checkout_flagger_seq.sv
// Directed bench for checkout_flagger_seq with CNT_W=4 and ALARM_HOLD=4.
module tb_checkout_flagger_seq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scan_valid = 1'b0;
    logic       scan_ready;
    logic [2:0] scan_upc = '0;
    logic       scan_mark = 1'b0;
    logic       alarm_ack = 1'b0;
    logic       discounted;
    logic       stolen_alarm;
    logic [2:0] last_upc;
    logic       last_valid;
    logic [3:0] item_count;
    logic [3:0] stolen_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    checkout_flagger_seq #(
        .UPC_W(3), .DISC_MASK(8'h26), .EXP_MASK(8'h89), .CNT_W(4), .ALARM_HOLD(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .scan_valid(scan_valid), .scan_ready(scan_ready),
        .scan_upc(scan_upc), .scan_mark(scan_mark),
        .alarm_ack(alarm_ack),
        .discounted(discounted), .stolen_alarm(stolen_alarm),
        .last_upc(last_upc), .last_valid(last_valid),
        .item_count(item_count), .stolen_count(stolen_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge while ready; returns #1 after the EVAL edge.
    task automatic do_scan(input logic [2:0] u, input logic m);
        $display("scan upc=%0d mark=%0d", u, m);
        scan_valid = 1'b1;
        scan_upc   = u;
        scan_mark  = m;
        @(posedge clk); #1;
        scan_valid = 1'b0;
        check("eval_ready", 32'(scan_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_ack();
        alarm_ack = 1'b1;
        @(posedge clk); #1;
        alarm_ack = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic r, input logic a, input logic d,
                               input logic [2:0] lu, input logic [3:0] ic, input logic [3:0] sc);
        check({tag, "_ready"},  32'(scan_ready),   32'(r));
        check({tag, "_alarm"},  32'(stolen_alarm), 32'(a));
        check({tag, "_disc"},   32'(discounted),   32'(d));
        check({tag, "_lupc"},   32'(last_upc),     32'(lu));
        check({tag, "_items"},  32'(item_count),   32'(ic));
        check({tag, "_stolen"}, 32'(stolen_count), 32'(sc));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_state("reset", 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
        check("reset_lvalid", 32'(last_valid), 32'd0);

        do_scan(3'd1, 1'b0);
        check_state("disc1", 1'b1, 1'b0, 1'b1, 3'd1, 4'd1, 4'd0);
        check("disc1_lvalid", 32'(last_valid), 32'd1);

        do_scan(3'd7, 1'b0);
        check_state("theft7", 1'b0, 1'b1, 1'b0, 3'd7, 4'd2, 4'd1);
`ifndef CHECKOUT_ALARM_AUTOCLR_EN
        // Offered items are ignored while the alarm is up.
        scan_valid = 1'b1;
        scan_upc   = 3'd2;
        scan_mark  = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        scan_valid = 1'b0;
        check_state("hold20", 1'b0, 1'b1, 1'b0, 3'd7, 4'd2, 4'd1);
`endif
        do_ack();
        check("ack_alarm", 32'(stolen_alarm), 32'd0);
        check("ack_ready", 32'(scan_ready), 32'd1);

        do_scan(3'd7, 1'b1);
        check_state("marked7", 1'b1, 1'b0, 1'b0, 3'd7, 4'd3, 4'd1);
        do_ack();
        check("idle_ack_alarm", 32'(stolen_alarm), 32'd0);
        check("idle_ack_ready", 32'(scan_ready), 32'd1);

        do_scan(3'd3, 1'b0);
        check_state("theft3", 1'b0, 1'b1, 1'b0, 3'd3, 4'd4, 4'd2);
        @(posedge clk); #1;
        check("ack_not_remembered", 32'(stolen_alarm), 32'd1);
        do_ack();
        check("ack3_alarm", 32'(stolen_alarm), 32'd0);

        do_scan(3'd2, 1'b0);
        check_state("disc2", 1'b1, 1'b0, 1'b1, 3'd2, 4'd5, 4'd2);
        repeat (3) @(posedge clk);
        #1;
        check("disc_hold", 32'(discounted), 32'd1);
        check("lupc_hold", 32'(last_upc), 32'd2);

        do_scan(3'd5, 1'b1);
        check_state("disc5", 1'b1, 1'b0, 1'b1, 3'd5, 4'd6, 4'd2);
        do_scan(3'd0, 1'b1);
        check_state("marked0", 1'b1, 1'b0, 1'b0, 3'd0, 4'd7, 4'd2);

        // Reset asserted while the alarm is latched.
        do_scan(3'd3, 1'b0);
        check_state("pre_rst", 1'b0, 1'b1, 1'b0, 3'd3, 4'd8, 4'd3);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_state("mid_rst", 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_state("post_rst", 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
        check("post_rst_lvalid", 32'(last_valid), 32'd0);

        for (int i = 0; i < 17; i++) begin
            do_scan(3'd3, 1'b0);
            check("sat_alarm", 32'(stolen_alarm), 32'd1);
            if (i == 13) begin
                check("sat_items14", 32'(item_count), 32'd14);
                check("sat_stolen14", 32'(stolen_count), 32'd14);
            end
            do_ack();
        end
        check("sat_items", 32'(item_count), 32'd15);
        check("sat_stolen", 32'(stolen_count), 32'd15);

`ifdef CHECKOUT_ALARM_AUTOCLR_EN
        do_scan(3'd0, 1'b0);
        check("auto_alarm_set", 32'(stolen_alarm), 32'd1);
        @(posedge clk); #1;
        check("auto_alarm_held", 32'(stolen_alarm), 32'd1);
        for (int i = 0; i < 3 && stolen_alarm; i++) begin
            @(posedge clk); #1;
        end
        check("auto_alarm_clr", 32'(stolen_alarm), 32'd0);
        check("auto_ready", 32'(scan_ready), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
